// File: rtl/bank_request_queue_pkg.sv
// Shared definitions for the per-bank request queue.
//   frontend_command_t : command word carried through the queues
//   ch_idx_t           : channel index type for the default channel count
//   *_DEF              : default values for the queue parameters
package bank_request_queue_pkg;

  localparam int NUM_CH_DEF     = 4;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int AF_MARGIN_DEF  = 2;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  tag;
    logic [23:0] addr;
  } frontend_command_t;

endpackage

// File: rtl/bank_request_queue_channel.sv
// One bank's circular FIFO: storage, wrap-bit pointers, registered flags.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wr_req       : accepted write (already qualified by !o_full)
//   i_wr_data      : command stored on an accepted write
//   i_rd_req       : accepted pop (already qualified by !o_empty)
//   o_rd_data      : head entry (first-word fall-through)
//   o_empty/o_full/o_afull/o_count : post-edge occupancy state
module req_queue_channel
  import bank_request_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_req,
  input  frontend_command_t     i_wr_data,
  input  logic                  i_rd_req,
  output frontend_command_t     o_rd_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

  frontend_command_t mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  n_wr, n_rd, n_count;

  // Flags are derived from the next pointers so they are valid right after
  // the edge that moved the pointers, with no extra cycle of latency.
  assign n_wr    = wr_ptr + PTR_W'(i_wr_req);
  assign n_rd    = rd_ptr + PTR_W'(i_rd_req);
  assign n_count = n_wr - n_rd;

  assign o_rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: storage is reset along with the pointers so a stale head never
  // shows X after reset; this costs a reset net on every storage flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
      o_afull <= 1'b0;
      o_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // pre-edge values regardless of statement order.
      wr_ptr  <= n_wr;
      rd_ptr  <= n_rd;
      o_empty <= (n_wr == n_rd);
      o_full  <= (n_wr == {~n_rd[PTR_W-1], n_rd[PTR_W-2:0]});
      o_afull <= (n_count >= AF_THRESH);
      o_count <= n_count;
      if (i_wr_req) mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
  end

  // Pointers advance by zero or one per cycle.
  a_wr_step: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (PTR_W'(wr_ptr - $past(wr_ptr)) <= PTR_W'(1)));
  a_rd_step: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (PTR_W'(rd_ptr - $past(rd_ptr)) <= PTR_W'(1)));
  // A full channel never takes a write; an empty one never takes a pop.
  a_full_no_wr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_full |-> !i_wr_req));
  a_empty_no_rd: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_empty |-> !i_rd_req));

endmodule

// File: rtl/bank_request_queue.sv
// Bank of NUM_CH independent request FIFOs with one write and one read port.
// Ports:
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_data, i_wr_en, i_wr_ch : enqueue command into channel i_wr_ch
//   i_rd_en, i_rd_ch   : pop channel i_rd_ch
//   o_data             : head of channel i_rd_ch (fall-through)
//   o_empty/o_full/o_afull : per-channel registered flag bitmaps
//   o_count            : packed per-channel occupancy, DEPTH_LOG2+1 bits each
//   o_wr_drop          : one-cycle pulse after a write hit a full channel
//   o_err              : sticky; dropped write or pop of an empty channel
module bank_request_queue
  import bank_request_queue_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  frontend_command_t                i_data,
  input  logic                             i_wr_en,
  input  logic [CH_W-1:0]                  i_wr_ch,
  input  logic                             i_rd_en,
  input  logic [CH_W-1:0]                  i_rd_ch,
  output frontend_command_t                o_data,
  output logic [NUM_CH-1:0]                o_empty,
  output logic [NUM_CH-1:0]                o_full,
  output logic [NUM_CH-1:0]                o_afull,
  output logic [NUM_CH*(DEPTH_LOG2+1)-1:0] o_count,
  output logic                             o_wr_drop,
  output logic                             o_err
);

  localparam int CNT_W = DEPTH_LOG2 + 1;

  frontend_command_t rd_data [NUM_CH];
  logic              wr_drop_now, rd_reject_now;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic wr_req, rd_req;

    // Requests are qualified by the registered flags, so a full channel
    // rejects a write even when it is popped in the same cycle.
    assign wr_req = i_wr_en && (i_wr_ch == CH_W'(k)) && !o_full[k];
    assign rd_req = i_rd_en && (i_rd_ch == CH_W'(k)) && !o_empty[k];

    req_queue_channel #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .AF_MARGIN  (AF_MARGIN)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_req  (wr_req),
      .i_wr_data (i_data),
      .i_rd_req  (rd_req),
      .o_rd_data (rd_data[k]),
      .o_empty   (o_empty[k]),
      .o_full    (o_full[k]),
      .o_afull   (o_afull[k]),
      .o_count   (o_count[k*CNT_W +: CNT_W])
    );
  end

  assign o_data        = rd_data[i_rd_ch];
  assign wr_drop_now   = i_wr_en && o_full[i_wr_ch];
  assign rd_reject_now = i_rd_en && o_empty[i_rd_ch];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_drop <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_wr_drop <= wr_drop_now;
      o_err     <= o_err | wr_drop_now | rd_reject_now;
    end
  end

endmodule

// File: tb/tb_bank_request_queue.sv
module tb_bank_request_queue;
  import bank_request_queue_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DL2    = 4;
  localparam int DEPTH  = 16;
  localparam int AFM    = 2;
  localparam int CW     = DL2 + 1;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  frontend_command_t i_data = '0;
  logic              i_wr_en = 1'b0;
  ch_idx_t           i_wr_ch = '0;
  logic              i_rd_en = 1'b0;
  ch_idx_t           i_rd_ch = '0;
  frontend_command_t o_data;
  logic [NUM_CH-1:0] o_empty, o_full, o_afull;
  logic [NUM_CH*CW-1:0] o_count;
  logic              o_wr_drop, o_err;

  bank_request_queue #(.NUM_CH(NUM_CH), .DEPTH_LOG2(DL2), .AF_MARGIN(AFM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_wr_en(i_wr_en),
    .i_wr_ch(i_wr_ch), .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .o_data(o_data),
    .o_empty(o_empty), .o_full(o_full), .o_afull(o_afull), .o_count(o_count),
    .o_wr_drop(o_wr_drop), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: one queue of words per channel, plus drop/err state.
  logic [31:0] mq [NUM_CH][$];
  bit          m_drop, m_err;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int k);
    return o_count[k*CW +: CW];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_CH; k++) mq[k].delete();
    m_drop = 0;
    m_err  = 0;
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]    e_empty, e_full, e_afull;
    logic [NUM_CH*CW-1:0] e_count;
    for (int k = 0; k < NUM_CH; k++) begin
      e_empty[k] = (mq[k].size() == 0);
      e_full[k]  = (mq[k].size() == DEPTH);
      e_afull[k] = (mq[k].size() >= DEPTH - AFM);
      e_count[k*CW +: CW] = CW'(mq[k].size());
    end
    check("o_empty", o_empty, e_empty);
    check("o_full", o_full, e_full);
    check("o_afull", o_afull, e_afull);
    check("o_count", o_count, e_count);
    check("o_wr_drop", o_wr_drop, m_drop);
    check("o_err", o_err, m_err);
  endtask

  // One clock of stimulus: drive after the falling edge, check the
  // fall-through head before the rising edge, advance the model, then
  // check every registered output just after the rising edge.
  task automatic cycle(input bit we, input int wc, input logic [31:0] d,
                       input bit re, input int rc);
    bit wr_acc, rd_acc;
    @(negedge i_clk);
    i_wr_en = we; i_wr_ch = ch_idx_t'(wc); i_data = d;
    i_rd_en = re; i_rd_ch = ch_idx_t'(rc);
    #1;
    if (mq[rc].size() != 0) check("o_data_head", o_data, mq[rc][0]);
    wr_acc = we && (mq[wc].size() < DEPTH);
    rd_acc = re && (mq[rc].size() != 0);
    m_drop = we && !wr_acc;
    m_err  = m_err | m_drop | (re && !rd_acc);
    if (rd_acc) void'(mq[rc].pop_front());
    if (wr_acc) mq[wc].push_back(d);
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_wr_en = 0; i_rd_en = 0;
    i_rst_n = 0;
    model_clear();
    @(posedge i_clk);
    #1;
    compare_all();
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  initial begin
    bit we, re;
    int ph;
    model_clear();
    do_reset();
    check("rst_empty", o_empty, 4'hF);
    check("rst_count", o_count, '0);
    check("rst_err", o_err, 1'b0);

    // Fill ch2 with 0x100..0x10F.
    for (int i = 0; i < 16; i++) begin
      cycle(1, 2, 32'h100 + i, 0, 0);
      check("afull2_fill", o_afull[2], (i + 1 >= 14));
    end
    check("full2", o_full[2], 1'b1);
    check("count2_16", cnt(2), 5'd16);
    check("empty_others", o_empty, 4'b1011);

    // Write to full ch2 is dropped.
    cycle(1, 2, 32'hDEAD, 0, 0);
    check("drop_pulse", o_wr_drop, 1'b1);
    check("err_on_drop", o_err, 1'b1);
    for (int i = 0; i < 16; i++) begin
      i_wr_en = 0; i_rd_en = 0; i_rd_ch = 2;
      #1;
      check("pop2_lit", o_data, 32'h100 + i);
      cycle(0, 0, 0, 1, 2);
      if (i == 0) check("drop_one_cycle", o_wr_drop, 1'b0);
    end
    check("ch2_drained", o_empty[2], 1'b1);

    // Write ch0 while popping ch1 in the same cycle.
    cycle(1, 1, 32'h77, 0, 0);
    i_wr_en = 0; i_rd_en = 0; i_rd_ch = 1;
    #1;
    check("ch1_head_lit", o_data, 32'h77);
    cycle(1, 0, 32'h55, 1, 1);
    check("ch0_count1", cnt(0), 5'd1);
    check("ch1_empty", o_empty[1], 1'b1);

    // ch3 holds one entry; write+pop together across 2.5 pointer wraps.
    cycle(1, 3, 32'h300, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 3, 32'h301 + i, 1, 3);
      check("ch3_count_steady", cnt(3), 5'd1);
    end

    // Empty ch1: simultaneous write and pop -> write only, error set.
    do_reset();
    cycle(1, 1, 32'h9, 1, 1);
    check("ch1_count_lit", cnt(1), 5'd1);
    check("ch1_err_lit", o_err, 1'b1);
    i_wr_en = 0; i_rd_en = 0; i_rd_ch = 1;
    #1;
    check("ch1_data9", o_data, 32'h9);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 150) % 2;
      we = ($urandom_range(99) < (ph == 0 ? 80 : 25));
      re = ($urandom_range(99) < (ph == 0 ? 25 : 80));
      cycle(we, int'($urandom_range(NUM_CH - 1)), $urandom(),
            re, int'($urandom_range(NUM_CH - 1)));
    end

    // Async reset mid-cycle with ch0 holding 5 entries.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'hA0 + i, 0, 0);
    check("ch0_count5", cnt(0), 5'd5);
    #2;
    i_wr_en = 0; i_rd_en = 0;
    i_rst_n = 0;
    #1;
    check("async_empty", o_empty, 4'hF);
    check("async_count", o_count, '0);
    model_clear();
    @(posedge i_clk);
    #1;
    compare_all();
    @(negedge i_clk);
    i_rst_n = 1;
    cycle(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
